rotary_menu_ctrl: RTL and testbench
===================================

# rotary_menu_ctrl

Sequencing controller for the rotary-encoder datapath. It consumes the one-cycle `right`/`left` step pulses and a debounced push-button tick, and gates the encoder through `enc_enable`. It runs a browse/edit menu over `N_ITEMS` stored parameter registers, each `VAL_W` bits wide. Downstream logic (game/display) reads committed values and receives one-cycle commit/cancel notifications.

## Interface
Parameters:
- `N_ITEMS`, 4: number of menu items, ≥2; `IDX_W = $clog2(N_ITEMS)`
- `VAL_W`, 8: width of each stored value
- `VAL_MAX`, 255: upper saturation bound, ≤ 2^VAL_W−1
- `STEP`, 1: increment per detent in edit mode
- `INIT_VAL`, 0: reset value of every item register
- `TIMEOUT_CYC`, 50_000_000: idle cycles in EDIT before auto-cancel, ≥2

Ports:
- `clk` in 1: system clock
- `reset` in 1: synchronous, active-high reset
- `right` in 1: one-cycle clockwise detent pulse from the encoder
- `left` in 1: one-cycle counter-clockwise detent pulse
- `press` in 1: one-cycle debounced push-button tick
- `lock` in 1: level; high holds the menu and disables the encoder
- `rd_item` in IDX_W: read address for stored values
- `enc_enable` out 1: enable to the encoder block
- `editing` out 1: high in EDIT state
- `item_idx` out IDX_W: currently selected item
- `disp_value` out VAL_W: value to display; shadow value in EDIT, stored value otherwise
- `rd_value` out VAL_W: combinational read of item `rd_item`
- `commit` out 1: one-cycle pulse when an edit is written
- `cancel` out 1: one-cycle pulse when an edit is discarded
- `commit_item` out IDX_W: item written (valid with `commit`)
- `commit_value` out VAL_W: value written (valid with `commit`)

## Operation
- States: LOCKED, BROWSE, EDIT.
- Reset values:
  - state = BROWSE
  - all items = INIT_VAL
  - `item_idx` = 0, shadow = 0, timeout counter = 0
  - `enc_enable` = 0, `editing` = 0, `commit` = 0, `cancel` = 0, `commit_item` = 0, `commit_value` = 0
- Event priority per cycle:
  1. `lock`
  2. `press`
  3. rotation
- `right && left` in the same cycle: both ignored.
- `press` together with rotation: `press` acts and the rotation is dropped.
- BROWSE:
  - `right`: `item_idx` +1, wrapping from N_ITEMS−1 to 0.
  - `left`: `item_idx` −1, wrapping from 0 to N_ITEMS−1.
  - `press`: shadow ← item[item_idx], timeout counter ← 0, go to EDIT.
- EDIT:
  - `right`: shadow ← min(shadow+STEP, VAL_MAX), with no overflow at VAL_W.
  - `left`: shadow ← max(shadow−STEP, 0), with no underflow.
  - Any accepted rotation clears the timeout counter.
  - `press`: item[item_idx] ← shadow; pulse `commit` with `commit_item`/`commit_value`; go to BROWSE.
  - Timeout counter reaching TIMEOUT_CYC−1 with no event: pulse `cancel`; item unchanged; go to BROWSE.
  - `item_idx` does not change in EDIT.
- LOCKED:
  - Entered from any state while `lock` = 1.
  - Entering from EDIT pulses `cancel` and discards the shadow.
  - Rotation and press inputs are ignored.
  - On `lock` falling, return to BROWSE with `item_idx` preserved.
- `enc_enable` is registered: it equals `!lock` delayed one cycle, and is 0 in the cycle after reset.
- `reset` during EDIT discards the edit. No `cancel` pulse is generated.

## Timing
- All outputs are registered except `rd_value` (combinational mux of item registers).
- An input pulse in cycle t is reflected in `item_idx`, `disp_value`, `editing`, `commit` and `cancel` in cycle t+1.
- `commit`/`cancel` are high for exactly one cycle. `commit_item`/`commit_value` hold until the next commit.
- `rd_value` shows the new value in the cycle after the `commit` edge, i.e. the same cycle `commit` is high.
- Timeout: with no accepted event after entering EDIT at cycle t0, `cancel` is asserted at cycle t0+TIMEOUT_CYC.
- Back-to-back pulses on consecutive cycles are each processed; none are lost.

## Test plan
- **Reset and enable.** Assert reset 2 cycles, then release with lock=0. Require `item_idx`=0, `editing`=0, and all rd_value=INIT_VAL. `enc_enable` is 0 in the first cycle after reset and 1 from the next cycle.
- **Browse wrap.** N_ITEMS=4. Apply 5 `right` pulses, expect `item_idx` sequence 1,2,3,0,1. Then apply 2 `left` pulses, expect 0,3.
- **Edit, saturate, commit.** VAL_MAX=10, STEP=3, item 2 = 8.
  - `press`, then `right` ×2: `disp_value` goes 8→10→10.
  - `left`: 7.
  - `press`: `commit`=1 for one cycle with commit_item=2, commit_value=7; rd_item=2 gives 7.
- **Underflow and simultaneous inputs.** In EDIT with shadow=1 and STEP=3, `left` gives 0. `right`+`left` in the same cycle leaves the shadow unchanged. `press`+`right` in the same cycle commits 0 with no increment.
- **Timeout.** TIMEOUT_CYC=16. Enter EDIT, apply `right` at cycle 5, then stay idle. `cancel` pulses exactly 16 cycles after that `right`. The item value is unchanged, and the state is BROWSE.
- **Lock mid-edit.** In EDIT with a modified shadow, raise `lock`.
  - Next cycle: `cancel`=1, `editing`=0. The following cycle `enc_enable`=0.
  - Rotation while locked leaves `item_idx` unchanged.
  - Drop `lock`: BROWSE with the same `item_idx`, and the item value is unchanged.

Source files
------------

// File: rtl/rotary_menu_ctrl.sv
// Browse/edit menu controller for a rotary encoder: selects one of N_ITEMS
// stored values, edits a shadow copy, then commits, cancels or times out.
module rotary_menu_ctrl #(
  parameter int N_ITEMS     = 4,
  parameter int VAL_W       = 8,
  parameter int VAL_MAX     = 255,
  parameter int STEP        = 1,
  parameter int INIT_VAL    = 0,
  parameter int TIMEOUT_CYC = 50_000_000,
  localparam int IDX_W      = $clog2(N_ITEMS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             right,
  input  logic             left,
  input  logic             press,
  input  logic             lock,
  input  logic [IDX_W-1:0] rd_item,
  output logic             enc_enable,
  output logic             editing,
  output logic [IDX_W-1:0] item_idx,
  output logic [VAL_W-1:0] disp_value,
  output logic [VAL_W-1:0] rd_value,
  output logic             commit,
  output logic             cancel,
  output logic [IDX_W-1:0] commit_item,
  output logic [VAL_W-1:0] commit_value
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ITEMS - 1);
  localparam logic [VAL_W:0]   STEP_X   = (VAL_W+1)'(STEP);
  localparam logic [VAL_W:0]   MAX_X    = (VAL_W+1)'(VAL_MAX);

  // Handshake: there is none; right/left/press are single-cycle strobes that
  // are always accepted, and commit/cancel are single-cycle strobes downstream
  // must capture in the cycle they are high.

  typedef enum logic [1:0] {LOCKED, BROWSE, EDIT} state_t;

  state_t           state, state_n;
  logic [VAL_W-1:0] items [N_ITEMS];
  logic [VAL_W-1:0] shadow, shadow_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [IDX_W-1:0] idx_n;
  logic [VAL_W-1:0] disp_n;
  logic             commit_n, cancel_n, we;
  logic             rot_r, rot_l;
  logic [VAL_W:0]   up_sum;
  logic [VAL_W-1:0] shadow_up, shadow_dn;

  // Opposite detents in one cycle cancel out and count as no event.
  assign rot_r = right & ~left;
  assign rot_l = left & ~right;

  assign up_sum    = {1'b0, shadow} + STEP_X;
  assign shadow_up = (up_sum > MAX_X) ? MAX_X[VAL_W-1:0] : up_sum[VAL_W-1:0];
  assign shadow_dn = ({1'b0, shadow} < STEP_X) ? '0 : shadow - STEP_X[VAL_W-1:0];

  assign rd_value = items[rd_item];
  assign editing  = (state == EDIT);

  always_comb begin
    state_n  = state;
    idx_n    = item_idx;
    shadow_n = shadow;
    cnt_n    = cnt;
    commit_n = 1'b0;
    cancel_n = 1'b0;
    we       = 1'b0;
    case (state)
      LOCKED: begin
        if (!lock) state_n = BROWSE;
      end
      BROWSE: begin
        if (lock) begin
          state_n = LOCKED;
        end else if (press) begin
          shadow_n = items[item_idx];
          cnt_n    = '0;
          state_n  = EDIT;
        end else if (rot_r) begin
          idx_n = (item_idx == LAST_IDX) ? '0 : item_idx + IDX_W'(1);
        end else if (rot_l) begin
          idx_n = (item_idx == '0) ? LAST_IDX : item_idx - IDX_W'(1);
        end
      end
      EDIT: begin
        if (lock) begin
          cancel_n = 1'b1;
          state_n  = LOCKED;
        end else if (press) begin
          we       = 1'b1;
          commit_n = 1'b1;
          state_n  = BROWSE;
        end else if (rot_r) begin
          shadow_n = shadow_up;
          cnt_n    = '0;
        end else if (rot_l) begin
          shadow_n = shadow_dn;
          cnt_n    = '0;
        end else if (cnt == CNT_LAST) begin
          cancel_n = 1'b1;
          state_n  = BROWSE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: state_n = BROWSE;
    endcase
    // The committed value bypasses the item array so the display is current.
    if (state_n == EDIT) disp_n = shadow_n;
    else if (we)         disp_n = shadow;
    else                 disp_n = items[idx_n];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= BROWSE;
      item_idx     <= '0;
      shadow       <= '0;
      cnt          <= '0;
      enc_enable   <= 1'b0;
      commit       <= 1'b0;
      cancel       <= 1'b0;
      commit_item  <= '0;
      commit_value <= '0;
      disp_value   <= VAL_W'(INIT_VAL);
      for (int i = 0; i < N_ITEMS; i++) items[i] <= VAL_W'(INIT_VAL);
    end else begin
      state      <= state_n;
      item_idx   <= idx_n;
      shadow     <= shadow_n;
      cnt        <= cnt_n;
      enc_enable <= ~lock;
      commit     <= commit_n;
      cancel     <= cancel_n;
      disp_value <= disp_n;
      if (we) begin
        items[item_idx] <= shadow;
        commit_item     <= item_idx;
        commit_value    <= shadow;
      end
    end
  end

endmodule

// File: tb/tb_rotary_menu_ctrl.sv
// Bench for rotary_menu_ctrl: directed vector table, timeout and lock
// sequences, then random stimulus against a behavioural menu model.
module tb_rotary_menu_ctrl;

  localparam int N    = 4;
  localparam int VW   = 8;
  localparam int VMAX = 10;
  localparam int STP  = 3;
  localparam int INIT = 2;
  localparam int TO   = 16;

  logic          clk = 1'b0;
  logic          reset, right, left, press, lock;
  logic [1:0]    rd_item;
  logic          enc_enable, editing, commit, cancel;
  logic [1:0]    item_idx, commit_item;
  logic [VW-1:0] disp_value, rd_value, commit_value;

  rotary_menu_ctrl #(
    .N_ITEMS(N), .VAL_W(VW), .VAL_MAX(VMAX), .STEP(STP),
    .INIT_VAL(INIT), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .reset(reset), .right(right), .left(left), .press(press),
    .lock(lock), .rd_item(rd_item), .enc_enable(enc_enable),
    .editing(editing), .item_idx(item_idx), .disp_value(disp_value),
    .rd_value(rd_value), .commit(commit), .cancel(cancel),
    .commit_item(commit_item), .commit_value(commit_value)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: menu mode flags, selected index, values, idle age.
  bit m_lock, m_edit, m_commit, m_cancel, m_enc;
  int m_idx, m_shadow, m_idle, m_ci, m_cv;
  int m_vals[N];

  typedef struct {
    bit r, l, p, lk;
    int idx;
    bit ed;
    int disp;
    bit cm, cn;
  } vec_t;
  vec_t tbl[23];

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic model_step(bit r, bit l, bit p, bit lk);
    m_commit = 0;
    m_cancel = 0;
    if (lk) begin
      if (m_edit) m_cancel = 1;
      m_edit = 0;
      m_lock = 1;
    end else if (m_lock) begin
      m_lock = 0;
    end else if (m_edit) begin
      if (p) begin
        m_vals[m_idx] = m_shadow;
        m_ci = m_idx;
        m_cv = m_shadow;
        m_commit = 1;
        m_edit = 0;
      end else if (r != l) begin
        if (r) m_shadow = (m_shadow + STP > VMAX) ? VMAX : m_shadow + STP;
        else   m_shadow = (m_shadow < STP) ? 0 : m_shadow - STP;
        m_idle = 0;
      end else begin
        m_idle++;
        if (m_idle == TO) begin
          m_cancel = 1;
          m_edit = 0;
        end
      end
    end else begin
      if (p) begin
        m_shadow = m_vals[m_idx];
        m_idle = 0;
        m_edit = 1;
      end else if (r != l) begin
        m_idx = (m_idx + (r ? 1 : N - 1)) % N;
      end
    end
    m_enc = !lk;
  endtask

  task automatic check_model();
    chk("item_idx", item_idx, m_idx);
    chk("editing", editing, m_edit);
    chk("disp_value", disp_value, m_edit ? m_shadow : m_vals[m_idx]);
    chk("commit", commit, m_commit);
    chk("cancel", cancel, m_cancel);
    chk("enc_enable", enc_enable, m_enc);
    chk("commit_item", commit_item, m_ci);
    chk("commit_value", commit_value, m_cv);
    rd_item = 2'($urandom_range(0, N - 1));
    #1;
    chk("rd_value", rd_value, m_vals[rd_item]);
  endtask

  task automatic step(bit r, bit l, bit p, bit lk);
    right = r;
    left  = l;
    press = p;
    lock  = lk;
    @(posedge clk);
    #1;
    model_step(r, l, p, lk);
    check_model();
  endtask

  initial begin
    int  n;
    bit  seen, lk, r, l, p;

    // r l p lk | idx ed disp commit cancel
    tbl[0]  = '{1,0,0,0, 1,0, 2,0,0};
    tbl[1]  = '{1,0,0,0, 2,0, 2,0,0};
    tbl[2]  = '{1,0,0,0, 3,0, 2,0,0};
    tbl[3]  = '{1,0,0,0, 0,0, 2,0,0};
    tbl[4]  = '{1,0,0,0, 1,0, 2,0,0};
    tbl[5]  = '{0,1,0,0, 0,0, 2,0,0};
    tbl[6]  = '{0,1,0,0, 3,0, 2,0,0};
    tbl[7]  = '{0,1,0,0, 2,0, 2,0,0};
    tbl[8]  = '{0,0,1,0, 2,1, 2,0,0};
    tbl[9]  = '{1,0,0,0, 2,1, 5,0,0};
    tbl[10] = '{1,0,0,0, 2,1, 8,0,0};
    tbl[11] = '{0,0,1,0, 2,0, 8,1,0};
    tbl[12] = '{0,0,1,0, 2,1, 8,0,0};
    tbl[13] = '{1,0,0,0, 2,1,10,0,0};
    tbl[14] = '{1,0,0,0, 2,1,10,0,0};
    tbl[15] = '{0,1,0,0, 2,1, 7,0,0};
    tbl[16] = '{0,0,1,0, 2,0, 7,1,0};
    tbl[17] = '{0,0,1,0, 2,1, 7,0,0};
    tbl[18] = '{0,1,0,0, 2,1, 4,0,0};
    tbl[19] = '{0,1,0,0, 2,1, 1,0,0};
    tbl[20] = '{0,1,0,0, 2,1, 0,0,0};
    tbl[21] = '{1,1,0,0, 2,1, 0,0,0};
    tbl[22] = '{1,0,1,0, 2,0, 0,1,0};

    // Clock/reset
    reset = 1'b1; right = 1'b0; left = 1'b0; press = 1'b0; lock = 1'b0;
    rd_item = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    m_lock = 0; m_edit = 0; m_commit = 0; m_cancel = 0; m_enc = 0;
    m_idx = 0; m_shadow = 0; m_idle = 0; m_ci = 0; m_cv = 0;
    for (int i = 0; i < N; i++) m_vals[i] = INIT;
    check_model();
    for (int i = 0; i < N; i++) begin
      rd_item = 2'(i);
      #1;
      chk("reset_rd_value", rd_value, INIT);
    end
    step(0, 0, 0, 0);
    chk("enc_enable_after_reset", enc_enable, 1);

    // Directed vector table
    for (int i = 0; i < 23; i++) begin
      step(tbl[i].r, tbl[i].l, tbl[i].p, tbl[i].lk);
      chk($sformatf("tbl%0d_idx", i), item_idx, tbl[i].idx);
      chk($sformatf("tbl%0d_editing", i), editing, tbl[i].ed);
      chk($sformatf("tbl%0d_disp", i), disp_value, tbl[i].disp);
      chk($sformatf("tbl%0d_commit", i), commit, tbl[i].cm);
      chk($sformatf("tbl%0d_cancel", i), cancel, tbl[i].cn);
    end
    chk("commit_item_final", commit_item, 2);
    chk("commit_value_final", commit_value, 0);

    // Timeout: cancel arrives TO cycles after the last accepted rotation
    step(0, 0, 1, 0);
    repeat (4) step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("timeout_shadow", disp_value, 3);
    n = 0;
    seen = 0;
    while (!seen && n < 40) begin
      step(0, 0, 0, 0);
      n++;
      if (cancel) seen = 1;
    end
    chk("timeout_cycles", n, TO);
    chk("timeout_editing", editing, 0);
    rd_item = 2'd2;
    #1;
    chk("timeout_item", rd_value, 0);

    // Lock during an edit
    step(0, 0, 1, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 1);
    chk("lock_cancel", cancel, 1);
    chk("lock_editing", editing, 0);
    step(1, 0, 0, 1);
    chk("lock_enc_enable", enc_enable, 0);
    chk("lock_idx_hold", item_idx, 2);
    step(0, 1, 1, 1);
    chk("lock_idx_hold2", item_idx, 2);
    step(0, 0, 0, 0);
    chk("unlock_idx", item_idx, 2);
    chk("unlock_editing", editing, 0);
    chk("unlock_value", disp_value, 0);

    // Random stimulus against the model
    lk = 0;
    repeat (800) begin
      if ($urandom_range(0, 39) == 0) lk = !lk;
      r = ($urandom_range(0, 3) == 0);
      l = ($urandom_range(0, 3) == 0);
      p = ($urandom_range(0, 9) == 0);
      step(r, l, p, lk);
    end
    repeat (3) step(0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
